// File: rtl/timer_mc_pkg.sv
// Shared types and register-map constants for the multi-channel system timer.
package timer_mc_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    localparam logic [3:0] OFS_CNT   = 4'd0;
    localparam logic [3:0] OFS_RLD   = 4'd4;
    localparam logic [3:0] OFS_CTRL  = 4'd8;
    localparam logic [3:0] OFS_STAT  = 4'd9;
    localparam logic [7:0] REG_FLAGS = 8'hF0;
    localparam int         CH_STRIDE = 16;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_LOAD   = 7;
    localparam int STAT_FLAG   = 0;

endpackage

// File: rtl/timer_mc_chan.sv
// One timer channel: count/reload/ctrl/flag/snapshot registers and the tick update rules.
module timer_mc_chan
    import timer_mc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       wr,
    input  logic       rd,
    input  logic [3:0] ofs,
    input  logic [7:0] di,
    input  logic       gclr,
    output logic [7:0] rdata,
    output logic       flag,
    output logic       irq_req
);
    localparam int NB = CNT_W / 8;

    logic [CNT_W-1:0] count, count_n, reload, reload_n, snap, snap_n;
    logic             en, en_n, irq_en, irq_en_n, flag_n;
    mode_e            mode, mode_n;
    logic             cnt_wr, ctrl_wr, set, clr;

    always_comb begin
        count_n  = count;
        reload_n = reload;
        snap_n   = snap;
        en_n     = en;
        mode_n   = mode;
        irq_en_n = irq_en;
        cnt_wr   = 1'b0;
        ctrl_wr  = 1'b0;
        set      = 1'b0;
        clr      = gclr;

        // Snapshot takes the pre-tick count so LSB-first reads stay coherent.
        if (rd && ofs == OFS_CNT) snap_n = count;

        if (wr) begin
            for (int b = 0; b < NB; b++) begin
                if (ofs == OFS_CNT + 4'(b)) begin
                    count_n[8*b +: 8] = di;
                    cnt_wr = 1'b1;
                end
                if (ofs == OFS_RLD + 4'(b)) reload_n[8*b +: 8] = di;
            end
            if (ofs == OFS_CTRL) begin
                ctrl_wr  = 1'b1;
                en_n     = di[CTRL_EN];
                mode_n   = mode_e'(di[CTRL_MODE +: 2]);
                irq_en_n = di[CTRL_IRQ_EN];
                if (di[CTRL_LOAD]) begin
                    count_n = reload;
                    cnt_wr  = 1'b1;
                end
            end
            if (ofs == OFS_STAT && di[STAT_FLAG]) clr = 1'b1;
        end

        // A CPU count write or load in the tick clk drops this channel's update.
        if (tick && en && !cnt_wr) begin
            case (mode)
                MODE_UP: begin
                    count_n = count + CNT_W'(1);
                    set     = &count;
                end
                MODE_ONESHOT: begin
                    if (count > CNT_W'(1)) count_n = count - CNT_W'(1);
                    else begin
                        count_n = '0;
                        set     = (count == CNT_W'(1));
                        if (!ctrl_wr) en_n = 1'b0;
                    end
                end
                MODE_PERIODIC: begin
                    if (count > CNT_W'(1)) count_n = count - CNT_W'(1);
                    else begin
                        count_n = reload;
                        set     = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        flag_n = set | (flag & ~clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            reload <= '0;
            snap   <= '0;
            en     <= 1'b0;
            mode   <= MODE_UP;
            irq_en <= 1'b0;
            flag   <= 1'b0;
        end else begin
            count  <= count_n;
            reload <= reload_n;
            snap   <= snap_n;
            en     <= en_n;
            mode   <= mode_n;
            irq_en <= irq_en_n;
            flag   <= flag_n;
        end
    end

    always_comb begin
        rdata = '0;
        for (int b = 0; b < NB; b++) begin
            if (ofs == OFS_CNT + 4'(b)) begin
                if (b == 0) rdata = count[7:0];
                else        rdata = snap[8*b +: 8];
            end
            if (ofs == OFS_RLD + 4'(b)) rdata = reload[8*b +: 8];
        end
        if (ofs == OFS_CTRL) rdata = {4'b0, irq_en, mode, en};
        if (ofs == OFS_STAT) rdata = {7'b0, flag};
    end

    assign irq_req = flag & irq_en;

endmodule

// File: rtl/timer_mc.sv
// Multi-channel system timer: shared prescaler, register decode, read mux and irq merge.
module timer_mc
    import timer_mc_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic       reg_ce,
    input  logic       reg_we,
    input  logic       reg_oe,
    input  logic [7:0] reg_addr,
    input  logic [7:0] reg_di,
    output logic [7:0] reg_do,
    output logic       irq,
    output logic       tick
);
    localparam int PRE_DIV = CLK_HZ / TICK_HZ;
    localparam int PW      = (PRE_DIV > 2) ? $clog2(PRE_DIV) : 1;

    logic [PW-1:0]                pre;
    logic                         wr_hit, rd_hit;
    logic [3:0]                   ch_sel;
    logic [CHANNELS-1:0]          flags, irq_req, gclr;
    logic [CHANNELS-1:0][7:0]     ch_do;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst)   pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + PW'(1);
    end

    assign tick   = (pre == PW'(PRE_DIV - 1));
    assign wr_hit = reg_ce & reg_we;
    assign rd_hit = reg_ce & reg_oe;
    assign ch_sel = reg_addr[7:4];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic sel;
        assign sel     = (int'(reg_addr) / CH_STRIDE == c);
        assign gclr[c] = wr_hit && (reg_addr == REG_FLAGS) && reg_di[c];

        timer_mc_chan #(.CNT_W(CNT_W)) u_chan (
            .clk     (clk),
            .rst     (sys_rst),
            .tick    (tick),
            .wr      (wr_hit & sel),
            .rd      (rd_hit & sel),
            .ofs     (reg_addr[3:0]),
            .di      (reg_di),
            .gclr    (gclr[c]),
            .rdata   (ch_do[c]),
            .flag    (flags[c]),
            .irq_req (irq_req[c])
        );
    end

    always_comb begin
        reg_do = '0;
        if (reg_addr == REG_FLAGS) reg_do = 8'(flags);
        else begin
            for (int c = 0; c < CHANNELS; c++)
                if (ch_sel == 4'(c)) reg_do = ch_do[c];
        end
    end

    assign irq = |irq_req;

endmodule

// File: doc/timer_mc.md
# timer_mc

Multi-channel system timer, parametrised successor of the single 1 kHz millisecond timer in the OS mapper. It provides CHANNELS independent CNT_W-bit counters driven from one shared prescaled tick. Each counter runs free-running-up, one-shot-down or periodic-down, and carries an expiry flag and a level IRQ. It sits behind the mapper's register decode (0x41xx window), which supplies single-cycle register strobes in the `clk` domain.

## Interface
- CLK_HZ, 50_000_000, frequency of `clk`
- TICK_HZ, 1000, tick rate; PRE_DIV = CLK_HZ/TICK_HZ, must be ≥2
- CHANNELS, 4, channel count, 1..8
- CNT_W, 16, counter width, 8/16/24/32; NB = CNT_W/8 bytes

- clk  in  1  system clock (mai.clk); the only clock
- sys_rst  in  1  reset, asynchronous, active-high
- reg_ce  in  1  timer window selected (decoded by mapper)
- reg_we  in  1  one-clk write strobe, qualified by reg_ce
- reg_oe  in  1  one-clk read strobe, qualified by reg_ce
- reg_addr  in  8  register offset within window
- reg_di  in  8  write data
- reg_do  out  8  read data, combinational from reg_addr
- irq  out  1  OR over channels of (flag & irq_en)
- tick  out  1  one-clk prescaler pulse, for debug/other blocks

## Operation
- Register map. Channel c occupies base c*16.
  - +0..+NB-1: count bytes, LSB first.
  - +4..+3+NB: reload bytes.
  - +8: ctrl. Bit0 en; bits2:1 mode (0 UP, 1 ONESHOT, 2 PERIODIC, 3 reserved = hold); bit3 irq_en; bit7 write-only load strobe (count <= reload).
  - +9: status. Bit0 flag; write 1 to clear.
  - 0xF0: read returns the flag bitmap [CHANNELS-1:0]; write-1 clears the matching flags.
  - Unmapped offsets and bytes ≥NB read 0x00, and writes to them are ignored.
- Snapshot. A reg_oe on count byte 0 returns live byte 0 and copies the whole count into snap[c]. Count bytes 1..NB-1 always read from snap[c]. Multi-byte reads are coherent when read LSB first.
- Prescaler. Counts 0..PRE_DIV-1 and wraps; `tick` is high during the terminal clk.
- Per-channel update occurs on `tick` when en=1:
  - UP: count+1. On wrap from all-ones to 0, flag set.
  - ONESHOT:
    - count>1: decrement.
    - count==1: count 0, flag set, en cleared.
    - count==0: en cleared, no flag.
  - PERIODIC:
    - count>1: decrement.
    - count≤1: count <= reload, flag set. reload==0 gives a flag every tick with count held at 0.
- Simultaneous events:
  - A CPU write to a count byte or the load strobe in the same clk as a tick: the CPU write wins and that channel's tick update is dropped.
  - An expiry in the same clk as a flag-clear write: set wins.
  - A ctrl write with en=1 in the same clk as a ONESHOT auto-disable: the CPU write wins.
- Reset (asynchronous, any time, including mid-count):
  - All count, reload, ctrl, flag and snap registers are 0.
  - Prescaler is 0; irq=0, tick=0.
  - reg_do is 0x00 unless a readable register is addressed.

## Timing
- Register writes take effect at the clk edge that samples reg_we. The value is readable the next clk.
- reg_do is valid in the same clk as reg_oe, with zero wait states.
- A tick-driven count/flag change is visible one clk after the tick-high clk. irq rises in that same clk.
- irq falls one clk after the clearing write, or one clk after irq_en is cleared.
- ONESHOT load N, en=1: the flag sets exactly N ticks later.
- PERIODIC reload R≥1: a flag every R ticks.
- The first tick after reset arrives PRE_DIV clks after release.
- Snapshot copy occurs at the reg_oe clk edge. A tick in the same clk is not included in the snapshot but is applied to the live count.

## Structure
- Package timer_mc_pkg holds:
  - mode enum (MODE_UP, MODE_ONESHOT, MODE_PERIODIC, MODE_HOLD);
  - offset constants (OFS_CNT=0, OFS_RLD=4, OFS_CTRL=8, OFS_STAT=9, REG_FLAGS=8'hF0, CH_STRIDE=16);
  - ctrl bit indices.
- Sub-module timer_mc_chan (one per channel, generate loop):
  - owns count, reload, ctrl, flag and snap;
  - inputs: tick, decoded per-channel write/read strobes, byte index, data;
  - outputs: read byte, flag, irq_req.
- The top level holds the prescaler, address decode, read mux and irq OR.

## Test plan
- Reset mid-count. ONESHOT load 5, assert sys_rst between ticks → all regs read 0x00, irq=0, the next tick is PRE_DIV clks after release.
- ONESHOT. Use CHANNELS=4, CNT_W=16, PRE_DIV=4 (CLK_HZ=4, TICK_HZ=1). On ch0 write reload 0x0003, load strobe, ctrl en|irq_en → irq rises exactly 3 ticks (12 clks) later, en reads 0, count 0x0000; write 0x01 to status → irq falls next clk.
- PERIODIC. On ch2 set reload 2 → flag every 2 ticks. Clear the flag in the same clk as an expiry → flag stays 1.
- UP wrap with snapshot. Set ch1 count 0xFFFF in UP mode → after 1 tick count 0x0000 and flag=1. Read byte0 just before a byte-1 rollover → byte1 returns the snapped value, not the post-tick value.
- CPU/tick collision. Write count byte0=0x10 in the tick clk → count reads 0x0010, not decremented. Write 0xFF to 0xF0 → all flags clear; unmapped offset 0x0A reads 0x00.
